clock_div_ctrl: RTL and testbench

//  Run/stop and reconfiguration controller for the board's 50 MHz-derived slow clock.

---
 rtl/clock_div_ctrl_pkg.sv | 24 ++
 rtl/clock_div_ctrl_half_cnt.sv | 48 ++++
 rtl/clock_div_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clock_div_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl_pkg
//   Shared definitions for the slow-clock run/stop/reconfiguration controller:
//   controller state encoding and the default divider settings.
// ---------------------------------------------------------------------------
package clock_div_ctrl_pkg;

   // Default counter width and half-period count (1 Hz from a 50 MHz clock:
   // each clockhz level lasts DEF_HALF+1 cycles).
   localparam int unsigned CNT_W_DEF    = 26;
   localparam int unsigned DEF_HALF_DEF = 24_999_999;

   // IDLE  : divider stopped, counter cleared, clockhz low
   // RUN   : divider counting
   // PEND  : counting, with a new half-period waiting for the next period boundary
   // STOPW : counting until the current period ends, then back to IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_STOPW = 2'd3
   } state_t;

endpackage

// File: rtl/clock_div_ctrl_half_cnt.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl_half_cnt
//   Half-period counter for the slow-clock divider. Counts 0..half while
//   enabled and wraps back to 0; clr forces the count to 0.
// Ports
//   clock50  in   1      system clock
//   clrn     in   1      asynchronous active-low reset
//   en       in   1      count enable
//   clr      in   1      synchronous clear (wins over en)
//   half     in   CNT_W  terminal count; one level lasts half+1 cycles
//   wrap     out  1      en and count==half: count returns to 0 on this edge
// ---------------------------------------------------------------------------
module clock_div_ctrl_half_cnt #(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clock50,
   input  logic             clrn,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] half,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Equality compare is enough: half only changes while the count is 0,
   // so the count can never step past it.
   assign wrap = en && (cnt_q == half);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock50 or negedge clrn) begin
      if (!clrn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// clock_div_ctrl
//   Run/stop and reconfiguration controller for the board's slow clock.
//   Holds the active half-period count, gates the divider counter, and takes
//   a new divisor through a req/ack handshake. While the divider is running
//   a new divisor is applied only at a full-period boundary (the falling
//   edge of clockhz), so clockhz never glitches.
// Ports
//   clock50   in   1      system clock (single domain)
//   clrn      in   1      asynchronous active-low reset
//   run       in   1      1 = divider runs, 0 = stop at end of current period
//   cfg_req   in   1      request to load cfg_half, held until cfg_ack
//   cfg_half  in   CNT_W  requested half-period count N (N+1 cycles per level)
//   cfg_ack   out  1      one-cycle pulse: cfg_half is now active
//   clockhz   out  1      divided clock, 50 % duty, registered
//   tick      out  1      one-cycle pulse in the cycle clockhz goes 0->1
//   busy      out  1      controller is not IDLE
//   cur_half  out  CNT_W  active half-period count
// ---------------------------------------------------------------------------
module clock_div_ctrl
   import clock_div_ctrl_pkg::*;
#(
   parameter int unsigned         CNT_W    = CNT_W_DEF,
   parameter logic [CNT_W-1:0]    DEF_HALF = CNT_W'(DEF_HALF_DEF)
) (
   input  logic             clock50,
   input  logic             clrn,
   input  logic             run,
   input  logic             cfg_req,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ack,
   output logic             clockhz,
   output logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] cur_half
);

   state_t           state_q,     state_d;
   logic             clockhz_q,   clockhz_d;
   logic             tick_q,      tick_d;
   logic             cfg_ack_q,   cfg_ack_d;
   logic [CNT_W-1:0] cur_half_q,  cur_half_d;
   logic [CNT_W-1:0] pend_half_q, pend_half_d;
   logic             req_block_q, req_block_d;

   logic wrap;
   logic counting;
   logic boundary;
   logic req_ok;

   assign counting = (state_q != ST_IDLE);

   clock_div_ctrl_half_cnt #(
      .CNT_W (CNT_W)
   ) u_half_cnt (
      .clock50 (clock50),
      .clrn    (clrn),
      .en      (counting),
      .clr     (!counting),
      .half    (cur_half_q),
      .wrap    (wrap)
   );

   // A wrap while clockhz is high ends the full period.
   assign boundary = wrap && clockhz_q;

   // After an ack the request stays blocked until cfg_req is seen low, so a
   // requester that keeps cfg_req high after the ack never loads twice.
   assign req_ok = cfg_req && !cfg_ack_q && !req_block_q;

   always_comb begin
      state_d     = state_q;
      clockhz_d   = clockhz_q;
      tick_d      = 1'b0;
      cfg_ack_d   = 1'b0;
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      req_block_d = req_block_q;

      if (!cfg_req) begin
         req_block_d = 1'b0;
      end

      if (wrap) begin
         clockhz_d = ~clockhz_q;
         tick_d    = ~clockhz_q;
      end

      case (state_q)
         ST_IDLE: begin
            clockhz_d = 1'b0;
            // Divider is stopped, so the new count can be applied at once.
            if (req_ok) begin
               cur_half_d  = cfg_half;
               cfg_ack_d   = 1'b1;
               req_block_d = 1'b1;
            end
            if (run) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (req_ok) begin
               pend_half_d = cfg_half;
               state_d     = ST_PEND;
            end else if (!run) begin
               state_d = ST_STOPW;
            end
         end

         ST_PEND: begin
            // run is only consulted at the boundary: a pending load always
            // completes before the divider stops.
            if (boundary) begin
               cur_half_d  = pend_half_q;
               cfg_ack_d   = 1'b1;
               req_block_d = 1'b1;
               state_d     = run ? ST_RUN : ST_IDLE;
            end
         end

         ST_STOPW: begin
            if (boundary) begin
               state_d = run ? ST_RUN : ST_IDLE;
            end else if (req_ok) begin
               pend_half_d = cfg_half;
               state_d     = ST_PEND;
            end else if (run) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock50 or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         clockhz_q   <= 1'b0;
         tick_q      <= 1'b0;
         cfg_ack_q   <= 1'b0;
         cur_half_q  <= DEF_HALF;
         pend_half_q <= '0;
         req_block_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clockhz_q   <= clockhz_d;
         tick_q      <= tick_d;
         cfg_ack_q   <= cfg_ack_d;
         cur_half_q  <= cur_half_d;
         pend_half_q <= pend_half_d;
         req_block_q <= req_block_d;
      end
   end

   assign clockhz  = clockhz_q;
   assign tick     = tick_q;
   assign cfg_ack  = cfg_ack_q;
   assign cur_half = cur_half_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_div_ctrl
//   Directed bench for clock_div_ctrl with an 8-bit counter and DEF_HALF=3.
//   Inputs change 1 ns after a rising edge; outputs are read at that point too.
// ---------------------------------------------------------------------------
module tb_clock_div_ctrl;

   localparam int W = 8;

   logic         clock50 = 1'b0;
   logic         clrn    = 1'b0;
   logic         run     = 1'b0;
   logic         cfg_req = 1'b0;
   logic [W-1:0] cfg_half = '0;
   logic         cfg_ack;
   logic         clockhz;
   logic         tick;
   logic         busy;
   logic [W-1:0] cur_half;

   int total = 0;
   int bad   = 0;

   clock_div_ctrl #(
      .CNT_W    (W),
      .DEF_HALF (8'd3)
   ) dut (
      .clock50  (clock50),
      .clrn     (clrn),
      .run      (run),
      .cfg_req  (cfg_req),
      .cfg_half (cfg_half),
      .cfg_ack  (cfg_ack),
      .clockhz  (clockhz),
      .tick     (tick),
      .busy     (busy),
      .cur_half (cur_half)
   );

   always #5 clock50 = ~clock50;

   task automatic step();
      @(posedge clock50);
      #1;
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      #12;
      total++; if (clockhz !== 1'b0) begin bad++; $display("FAIL reset_clockhz got=%b want=0", clockhz); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
      total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", cfg_ack); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (cur_half !== 8'd3) begin bad++; $display("FAIL reset_cur_half got=%0d want=3", cur_half); end
      step();
      clrn = 1'b1;
      step();
      $display("test_reset done");
   endtask

   // half=3: first rise 4 cycles after entering RUN, period 8.
   task automatic test_run_default();
      logic exp_hz, exp_tick;
      run = 1'b1;
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%b want=1", busy); end
      total++; if (clockhz !== 1'b0) begin bad++; $display("FAIL run_start_hz got=%b want=0", clockhz); end
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_hz   = ((k / 4) % 2) == 1;
         exp_tick = (k % 8) == 4;
         total++; if (clockhz !== exp_hz) begin bad++; $display("FAIL run_hz k=%0d got=%b want=%b", k, clockhz, exp_hz); end
         total++; if (tick !== exp_tick) begin bad++; $display("FAIL run_tick k=%0d got=%b want=%b", k, tick, exp_tick); end
      end
      $display("test_run_default done");
   endtask

   // run drops one cycle into the high phase: high phase finishes, then IDLE.
   task automatic test_stop();
      logic exp_act;
      run = 1'b0;
      for (int k = 21; k <= 24; k++) begin
         step();
         exp_act = (k < 24);
         total++; if (clockhz !== exp_act) begin bad++; $display("FAIL stop_hz k=%0d got=%b want=%b", k, clockhz, exp_act); end
         total++; if (busy !== exp_act) begin bad++; $display("FAIL stop_busy k=%0d got=%b want=%b", k, busy, exp_act); end
         total++; if (tick !== 1'b0) begin bad++; $display("FAIL stop_tick k=%0d got=%b want=0", k, tick); end
      end
      $display("test_stop done");
   endtask

   // IDLE load of half=1 (ack next cycle), then period 4, with a stop/restart
   // inside a high phase that must not leave a gap.
   task automatic test_cfg_idle();
      logic exp_hz, exp_tick;
      int   n;
      cfg_half = 8'd1;
      cfg_req  = 1'b1;
      step();
      total++; if (cfg_ack !== 1'b1) begin bad++; $display("FAIL idle_ack got=%b want=1", cfg_ack); end
      total++; if (cur_half !== 8'd1) begin bad++; $display("FAIL idle_cur_half got=%0d want=1", cur_half); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
      cfg_req = 1'b0;
      step();
      total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL idle_ack_pulse got=%b want=0", cfg_ack); end
      run = 1'b1;
      step();
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_hz   = ((k / 2) % 2) == 1;
         exp_tick = (k % 4) == 2;
         total++; if (clockhz !== exp_hz) begin bad++; $display("FAIL h1_hz k=%0d got=%b want=%b", k, clockhz, exp_hz); end
         total++; if (tick !== exp_tick) begin bad++; $display("FAIL h1_tick k=%0d got=%b want=%b", k, tick, exp_tick); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL h1_busy k=%0d got=%b want=1", k, busy); end
         if (k == 10) run = 1'b0;
         if (k == 11) run = 1'b1;
      end
      run = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 10) begin
         step();
         n++;
      end
      total++; if (n != 4) begin bad++; $display("FAIL h1_stop_cycles got=%0d want=4", n); end
      total++; if (clockhz !== 1'b0) begin bad++; $display("FAIL h1_stop_hz got=%b want=0", clockhz); end
      $display("test_cfg_idle done");
   endtask

   // Running half=3, request half=0 mid high phase, held 5 cycles past ack.
   task automatic test_cfg_running();
      logic         exp_hz, exp_tick, exp_ack;
      logic [W-1:0] exp_half;
      int           acks;
      cfg_half = 8'd3;
      cfg_req  = 1'b1;
      step();
      total++; if (cur_half !== 8'd3) begin bad++; $display("FAIL reload3_cur_half got=%0d want=3", cur_half); end
      cfg_req = 1'b0;
      step();
      run = 1'b1;
      step();
      acks = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k <= 7) begin
            exp_hz = ((k / 4) % 2) == 1; exp_tick = (k == 4); exp_ack = 1'b0; exp_half = 8'd3;
         end else if (k == 8) begin
            exp_hz = 1'b0; exp_tick = 1'b0; exp_ack = 1'b1; exp_half = 8'd0;
         end else begin
            exp_hz = ((k - 8) % 2) == 1; exp_tick = exp_hz; exp_ack = 1'b0; exp_half = 8'd0;
         end
         if (cfg_ack === 1'b1) acks++;
         total++; if (clockhz !== exp_hz) begin bad++; $display("FAIL rcfg_hz k=%0d got=%b want=%b", k, clockhz, exp_hz); end
         total++; if (tick !== exp_tick) begin bad++; $display("FAIL rcfg_tick k=%0d got=%b want=%b", k, tick, exp_tick); end
         total++; if (cfg_ack !== exp_ack) begin bad++; $display("FAIL rcfg_ack k=%0d got=%b want=%b", k, cfg_ack, exp_ack); end
         total++; if (cur_half !== exp_half) begin bad++; $display("FAIL rcfg_cur_half k=%0d got=%0d want=%0d", k, cur_half, exp_half); end
         if (k == 5) begin cfg_half = 8'd0; cfg_req = 1'b1; end
         if (k == 13) cfg_req = 1'b0;
      end
      total++; if (acks != 1) begin bad++; $display("FAIL rcfg_ack_count got=%0d want=1", acks); end
      $display("test_cfg_running done");
   endtask

   // Enter PEND, then reset asynchronously: no ack, defaults restored.
   task automatic test_reset_in_pend();
      cfg_half = 8'd5;
      cfg_req  = 1'b1;
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend_busy got=%b want=1", busy); end
      total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL pend_ack got=%b want=0", cfg_ack); end
      total++; if (cur_half !== 8'd0) begin bad++; $display("FAIL pend_cur_half got=%0d want=0", cur_half); end
      #1;
      clrn = 1'b0;
      #1;
      total++; if (clockhz !== 1'b0) begin bad++; $display("FAIL arst_hz got=%b want=0", clockhz); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
      total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL arst_ack got=%b want=0", cfg_ack); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL arst_tick got=%b want=0", tick); end
      total++; if (cur_half !== 8'd3) begin bad++; $display("FAIL arst_cur_half got=%0d want=3", cur_half); end
      cfg_req = 1'b0;
      run     = 1'b0;
      step();
      clrn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL arst_post_ack k=%0d got=%b want=0", k, cfg_ack); end
         total++; if (cur_half !== 8'd3) begin bad++; $display("FAIL arst_post_half k=%0d got=%0d want=3", k, cur_half); end
      end
      $display("test_reset_in_pend done");
   endtask

   // Held request loads once; a fresh request after a drop loads again.
   task automatic test_back_to_back();
      cfg_half = 8'd2;
      cfg_req  = 1'b1;
      step();
      total++; if (cfg_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b want=1", cfg_ack); end
      total++; if (cur_half !== 8'd2) begin bad++; $display("FAIL b2b_half1 got=%0d want=2", cur_half); end
      cfg_half = 8'd5;
      for (int k = 0; k < 2; k++) begin
         step();
         total++; if (cfg_ack !== 1'b0) begin bad++; $display("FAIL b2b_held_ack k=%0d got=%b want=0", k, cfg_ack); end
         total++; if (cur_half !== 8'd2) begin bad++; $display("FAIL b2b_held_half k=%0d got=%0d want=2", k, cur_half); end
      end
      cfg_req = 1'b0;
      step();
      cfg_req = 1'b1;
      step();
      total++; if (cfg_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b want=1", cfg_ack); end
      total++; if (cur_half !== 8'd5) begin bad++; $display("FAIL b2b_half2 got=%0d want=5", cur_half); end
      cfg_req = 1'b0;
      step();
      $display("test_back_to_back done");
   endtask

   initial begin
      test_reset();
      test_run_default();
      test_stop();
      test_cfg_idle();
      test_cfg_running();
      test_reset_in_pend();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
